// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and external memory bus signals of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_flush;
  logic        f_valid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        err;

  modport slave (
    input  f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  bus_ack, bus_rdata,
    output f_valid, f_rdata, d_valid, d_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, busy, err
  );

  modport master (
    output f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata, d_wstrb,
    output bus_ack, bus_rdata,
    input  f_valid, f_rdata, d_valid, d_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and data access.
// Define ARB_TIMEOUT_EN to add a bus watchdog that aborts stalled transactions and pulses err.
module mem_port_arbiter #(
  parameter int DATA_BURST_MAX = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              iclk,
  input logic              irst,
  mem_port_arbiter_if.slave arb
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t      state;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_wstrb_q;
  logic        f_valid_q;
  logic [31:0] f_rdata_q;
  logic        d_valid_q;
  logic [31:0] d_rdata_q;
  logic [3:0]  cnt;
  logic        drop;
  logic        fr;
  logic        dr;
  logic        burst_full;

  if (DATA_BURST_MAX < 1 || DATA_BURST_MAX > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mem_port_arbiter: DATA_BURST_MAX or TIMEOUT_CYCLES out of range");
  end

  // A requester is masked during its own response cycle so a held request is not re-granted.
  assign fr         = arb.f_req & ~arb.f_flush & ~f_valid_q;
  assign dr         = arb.d_req & ~d_valid_q;
  assign burst_full = fr && (cnt == 4'(DATA_BURST_MAX));

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wdog;
  logic        err_q;
  logic        timeout;
  assign timeout = ~arb.bus_ack && (wdog == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state       <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_wstrb_q <= 4'h0;
      f_valid_q   <= 1'b0;
      f_rdata_q   <= 32'h0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= 32'h0;
      cnt         <= 4'h0;
      drop        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wdog        <= 16'h0;
      err_q       <= 1'b0;
`endif
    end else begin
      f_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          wdog <= 16'h0;
`endif
          // Data wins unless a waiting fetch has already sat through a full data burst.
          if (dr && !burst_full) begin
            state       <= DATA;
            bus_req_q   <= 1'b1;
            bus_we_q    <= arb.d_we;
            bus_addr_q  <= arb.d_addr;
            bus_wdata_q <= arb.d_wdata;
            bus_wstrb_q <= arb.d_we ? arb.d_wstrb : 4'h0;
            cnt         <= fr ? cnt + 4'd1 : 4'h0;
          end else if (fr) begin
            state       <= FETCH;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= arb.f_addr;
            bus_wstrb_q <= 4'h0;
            cnt         <= 4'h0;
          end else if (!arb.f_req) begin
            cnt <= 4'h0;
          end
        end
        FETCH: begin
          if (arb.bus_ack) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
            drop      <= 1'b0;
            if (!drop && !arb.f_flush) begin
              f_valid_q <= 1'b1;
              f_rdata_q <= arb.bus_rdata;
            end
`ifdef ARB_TIMEOUT_EN
          end else if (timeout) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
            drop      <= 1'b0;
            err_q     <= 1'b1;
            if (!drop && !arb.f_flush) begin
              f_valid_q <= 1'b1;
              f_rdata_q <= 32'h0;
            end
`endif
          end else begin
            if (arb.f_flush) drop <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            wdog <= wdog + 16'd1;
`endif
          end
        end
        DATA: begin
          if (arb.bus_ack) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
            d_valid_q <= 1'b1;
            d_rdata_q <= arb.bus_rdata;
`ifdef ARB_TIMEOUT_EN
          end else if (timeout) begin
            state     <= IDLE;
            bus_req_q <= 1'b0;
            err_q     <= 1'b1;
            d_valid_q <= 1'b1;
            d_rdata_q <= 32'h0;
          end else begin
            wdog <= wdog + 16'd1;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign arb.bus_req   = bus_req_q;
  assign arb.bus_we    = bus_we_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.bus_wstrb = bus_wstrb_q;
  assign arb.f_valid   = f_valid_q;
  assign arb.f_rdata   = f_rdata_q;
  assign arb.d_valid   = d_valid_q;
  assign arb.d_rdata   = d_rdata_q;
  assign arb.busy      = (state != IDLE);
`ifdef ARB_TIMEOUT_EN
  assign arb.err       = err_q;
`else
  assign arb.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, a per-cycle vector table, burst fairness and,
// when ARB_TIMEOUT_EN is defined, the watchdog abort.
module tb_mem_port_arbiter;

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
  } in_t;

  typedef struct {
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        f_valid;
    logic [31:0] f_rdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        busy;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t ex;
  } vec_t;

  localparam int NV = 25;
  localparam logic [31:0] FI0 = 32'h00500093;
  localparam logic [31:0] FI1 = 32'h00A00113;

  logic iclk = 1'b0;
  logic irst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [NV];

  mem_port_arbiter_if ifc ();

  mem_port_arbiter #(.DATA_BURST_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .iclk(iclk),
    .irst(irst),
    .arb (ifc)
  );

  always #5 iclk = ~iclk;

  task automatic applyStimulus(input in_t s);
    ifc.f_req     = s.f_req;
    ifc.f_addr    = s.f_addr;
    ifc.f_flush   = s.f_flush;
    ifc.d_req     = s.d_req;
    ifc.d_we      = s.d_we;
    ifc.d_addr    = s.d_addr;
    ifc.d_wdata   = s.d_wdata;
    ifc.d_wstrb   = s.d_wstrb;
    ifc.bus_ack   = s.bus_ack;
    ifc.bus_rdata = s.bus_rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    in_t idle_in;
    int  n;
    logic is_fetch [6];
    logic [3:0] wst [6];
    logic exp_fetch [6];

    idle_in = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0};
    exp_fetch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // in: f_req f_addr f_flush d_req d_we d_addr d_wdata d_wstrb bus_ack bus_rdata
    // ex: bus_req bus_addr bus_we bus_wdata bus_wstrb f_valid f_rdata d_valid d_rdata busy
    vecs[0]  = '{'{1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0},            '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1}};
    vecs[1]  = '{'{1, 32'h100, 0, 0, 0, 0, 0, 0, 1, FI0},          '{0, 0, 0, 0, 0, 1, FI0, 0, 0, 0}};
    vecs[2]  = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},                  '{0, 0, 0, 0, 0, 0, FI0, 0, 0, 0}};
    vecs[3]  = '{'{0, 0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0}, '{1, 32'h2000, 1, 32'hDEADBEEF, 4'b0011, 0, FI0, 0, 0, 1}};
    vecs[4]  = '{'{0, 0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0}, '{1, 32'h2000, 1, 32'hDEADBEEF, 4'b0011, 0, FI0, 0, 0, 1}};
    vecs[5]  = '{'{0, 0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0}, '{1, 32'h2000, 1, 32'hDEADBEEF, 4'b0011, 0, FI0, 0, 0, 1}};
    vecs[6]  = '{'{0, 0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0}, '{1, 32'h2000, 1, 32'hDEADBEEF, 4'b0011, 0, FI0, 0, 0, 1}};
    vecs[7]  = '{'{0, 0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 1, 0}, '{0, 0, 0, 0, 0, 0, FI0, 1, 0, 0}};
    vecs[8]  = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},                  '{0, 0, 0, 0, 0, 0, FI0, 0, 0, 0}};
    vecs[9]  = '{'{1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0},            '{1, 32'h300, 0, 0, 0, 0, FI0, 0, 0, 1}};
    vecs[10] = '{'{1, 32'h300, 1, 0, 0, 0, 0, 0, 0, 0},            '{1, 32'h300, 0, 0, 0, 0, FI0, 0, 0, 1}};
    vecs[11] = '{'{1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 32'h1234},     '{0, 0, 0, 0, 0, 0, FI0, 0, 0, 0}};
    vecs[12] = '{'{1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0},            '{1, 32'h200, 0, 0, 0, 0, FI0, 0, 0, 1}};
    vecs[13] = '{'{1, 32'h200, 0, 0, 0, 0, 0, 0, 1, FI1},          '{0, 0, 0, 0, 0, 1, FI1, 0, 0, 0}};
    vecs[14] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},                  '{0, 0, 0, 0, 0, 0, FI1, 0, 0, 0}};
    vecs[15] = '{'{1, 32'h400, 1, 0, 0, 0, 0, 0, 0, 0},            '{0, 0, 0, 0, 0, 0, FI1, 0, 0, 0}};
    vecs[16] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},                  '{0, 0, 0, 0, 0, 0, FI1, 0, 0, 0}};
    vecs[17] = '{'{0, 0, 0, 1, 0, 32'h3000, 0, 4'hF, 0, 0},        '{1, 32'h3000, 0, 0, 4'h0, 0, FI1, 0, 0, 1}};
    vecs[18] = '{'{0, 0, 0, 1, 0, 32'h3000, 0, 4'hF, 1, 32'hCAFEF00D}, '{0, 0, 0, 0, 0, 0, FI1, 1, 32'hCAFEF00D, 0}};
    vecs[19] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},                  '{0, 0, 0, 0, 0, 0, FI1, 0, 32'hCAFEF00D, 0}};
    vecs[20] = '{'{1, 32'h500, 0, 1, 0, 32'h600, 0, 0, 0, 0},      '{1, 32'h600, 0, 0, 0, 0, FI1, 0, 32'hCAFEF00D, 1}};
    vecs[21] = '{'{1, 32'h500, 0, 1, 0, 32'h600, 0, 0, 1, 32'h11111111}, '{0, 0, 0, 0, 0, 0, FI1, 1, 32'h11111111, 0}};
    vecs[22] = '{'{1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0},            '{1, 32'h500, 0, 0, 0, 0, FI1, 0, 32'h11111111, 1}};
    vecs[23] = '{'{1, 32'h500, 0, 0, 0, 0, 0, 0, 1, 32'h22222222}, '{0, 0, 0, 0, 0, 1, 32'h22222222, 0, 32'h11111111, 0}};
    vecs[24] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},                  '{0, 0, 0, 0, 0, 0, 32'h22222222, 0, 32'h11111111, 0}};

    applyStimulus(idle_in);
    repeat (2) @(posedge iclk);
    @(negedge iclk) irst = 1'b0;
    @(posedge iclk) #1;
    checkOutput("reset.bus_req", ifc.bus_req, 0);
    checkOutput("reset.busy", ifc.busy, 0);
    checkOutput("reset.f_valid", ifc.f_valid, 0);
    checkOutput("reset.d_valid", ifc.d_valid, 0);
    checkOutput("reset.err", ifc.err, 0);

    // Reset in the middle of a stalled store must drop the bus immediately.
    @(negedge iclk);
    applyStimulus('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0});
    @(posedge iclk) #1;
    checkOutput("rst_mid.pre_bus_req", ifc.bus_req, 1);
    @(posedge iclk) #1;
    #2 irst = 1'b1;
    #1;
    checkOutput("rst_mid.bus_req", ifc.bus_req, 0);
    checkOutput("rst_mid.busy", ifc.busy, 0);
    checkOutput("rst_mid.bus_addr", ifc.bus_addr, 0);
    checkOutput("rst_mid.bus_we", ifc.bus_we, 0);
    checkOutput("rst_mid.bus_wdata", ifc.bus_wdata, 0);
    checkOutput("rst_mid.bus_wstrb", ifc.bus_wstrb, 0);
    @(negedge iclk);
    irst = 1'b0;
    applyStimulus(idle_in);
    ifc.bus_ack = 1'b1;
    @(posedge iclk) #1;
    checkOutput("rst_late_ack.busy", ifc.busy, 0);
    checkOutput("rst_late_ack.d_valid", ifc.d_valid, 0);
    checkOutput("rst_late_ack.d_rdata", ifc.d_rdata, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge iclk);
      applyStimulus(vecs[i].in);
      @(posedge iclk) #1;
      checkOutput($sformatf("v%0d.bus_req", i), ifc.bus_req, vecs[i].ex.bus_req);
      checkOutput($sformatf("v%0d.busy", i), ifc.busy, vecs[i].ex.busy);
      checkOutput($sformatf("v%0d.f_valid", i), ifc.f_valid, vecs[i].ex.f_valid);
      checkOutput($sformatf("v%0d.f_rdata", i), ifc.f_rdata, vecs[i].ex.f_rdata);
      checkOutput($sformatf("v%0d.d_valid", i), ifc.d_valid, vecs[i].ex.d_valid);
      checkOutput($sformatf("v%0d.d_rdata", i), ifc.d_rdata, vecs[i].ex.d_rdata);
      checkOutput($sformatf("v%0d.err", i), ifc.err, 0);
      if (vecs[i].ex.bus_req) begin
        checkOutput($sformatf("v%0d.bus_addr", i), ifc.bus_addr, vecs[i].ex.bus_addr);
        checkOutput($sformatf("v%0d.bus_we", i), ifc.bus_we, vecs[i].ex.bus_we);
        checkOutput($sformatf("v%0d.bus_wstrb", i), ifc.bus_wstrb, vecs[i].ex.bus_wstrb);
        if (vecs[i].ex.bus_we)
          checkOutput($sformatf("v%0d.bus_wdata", i), ifc.bus_wdata, vecs[i].ex.bus_wdata);
      end
    end

    // Both requesters held; fetch is flushed in each data response cycle so the burst
    // counter can build up, and acks are returned in the first bus cycle.
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      @(negedge iclk);
      if (ifc.bus_req) begin
        is_fetch[n] = (ifc.bus_addr == 32'h1000);
        wst[n] = ifc.bus_wstrb;
        n++;
      end
      ifc.f_req     = 1'b1;
      ifc.f_addr    = 32'h1000;
      ifc.d_req     = 1'b1;
      ifc.d_we      = 1'b0;
      ifc.d_addr    = 32'h2000;
      ifc.d_wstrb   = 4'hF;
      ifc.bus_rdata = 32'h5A5A5A5A;
      ifc.f_flush   = ifc.d_valid;
      ifc.bus_ack   = ifc.bus_req;
    end
    checkOutput("burst.grant_count", n, 6);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("burst.grant%0d_is_fetch", i), is_fetch[i], exp_fetch[i]);
      checkOutput($sformatf("burst.grant%0d_wstrb", i), wst[i], 0);
    end
    @(negedge iclk);
    applyStimulus(idle_in);
    repeat (3) @(negedge iclk);

`ifdef ARB_TIMEOUT_EN
    applyStimulus('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0, 1'b0, 32'h0});
    for (int i = 1; i <= 8; i++) begin
      @(posedge iclk) #1;
      checkOutput($sformatf("timeout.bus_req_c%0d", i), ifc.bus_req, 1);
      checkOutput($sformatf("timeout.err_c%0d", i), ifc.err, 0);
    end
    @(posedge iclk) #1;
    checkOutput("timeout.bus_req_drop", ifc.bus_req, 0);
    checkOutput("timeout.err", ifc.err, 1);
    checkOutput("timeout.d_valid", ifc.d_valid, 1);
    checkOutput("timeout.d_rdata", ifc.d_rdata, 0);
    checkOutput("timeout.busy", ifc.busy, 0);
    @(negedge iclk);
    applyStimulus(idle_in);
    @(posedge iclk) #1;
    checkOutput("timeout.err_clear", ifc.err, 0);
    checkOutput("timeout.d_valid_clear", ifc.d_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported external memory bus between the pipeline fetch stage (instruction reads) and the memory stage (data loads and stores).
- Sits between the core datapath/hazard logic and the unified memory.
- Serialises requests and returns read data to the right requester with a one-cycle valid pulse.
- Exports busy for the hazard unit's stall generation.

Parameters:
- DATA_BURST_MAX, 4: maximum consecutive data grants while a fetch is pending before fetch is forced a grant; legal range 1..15.
- TIMEOUT_CYCLES, 64: bus watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- iclk  in  1  clock, rising edge
- irst  in  1  reset, asynchronous, active-high
- f_req  in  1  fetch request; held with f_addr stable until f_valid
- f_addr  in  32  fetch address
- f_flush  in  1  fetch redirect; kill current or pending fetch response
- f_valid  out  1  fetch response pulse
- f_rdata  out  32  fetched instruction, valid with f_valid
- d_req  in  1  data request; held with fields stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_valid  out  1  data response pulse; for stores this is the completion
- d_rdata  out  32  load data, valid with d_valid
- bus_req  out  1  bus request, registered
- bus_we  out  1  bus write enable
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_wstrb  out  4  bus byte strobes; 4'h0 on reads
- bus_ack  in  1  single-cycle completion; bus_rdata valid in the same cycle
- bus_rdata  in  32  bus read data
- busy  out  1  high in FETCH or DATA state
- err  out  1  timeout pulse; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset: state IDLE; all outputs 0; burst counter 0; drop flag 0. Reset takes effect immediately, including mid-transaction. An outstanding bus transaction is abandoned and its late bus_ack is ignored because bus_req is 0.
- States:
  - IDLE: bus_req = 0.
  - FETCH: bus_req = 1, bus_addr = latched f_addr, bus_we = 0, bus_wstrb = 0.
  - DATA: bus_req = 1, bus_addr, bus_we, bus_wdata and bus_wstrb latched from the d_* inputs.
- Bus fields are latched at grant and held stable until bus_ack.
- IDLE transitions:
  - Effective requests: fr = f_req & ~f_flush & ~f_valid; dr = d_req & ~d_valid. This masks the requester in its own response cycle.
  - dr & ~(fr & cnt == DATA_BURST_MAX): go to DATA; increment cnt if fr, else clear cnt.
  - fr (otherwise): go to FETCH; clear cnt.
  - Neither: stay in IDLE; clear cnt when f_req = 0.
- FETCH or DATA with bus_ack = 1: return to IDLE. On the next edge, register bus_rdata into f_rdata or d_rdata and pulse the matching valid for one cycle.
- Latency: request in IDLE at cycle N; bus_req from N+1; bus_ack at N+1+k; valid at N+2+k. Minimum is 2 cycles.
- Earliest next grant is the cycle after bus_ack. Peak rate is one transaction per 2 cycles.
- Flush:
  - f_flush in FETCH sets the drop flag. The bus transaction still completes.
  - On its ack, f_valid stays 0 and f_rdata is unchanged. The drop flag clears on leaving FETCH.
  - f_flush in IDLE blocks a fetch grant that cycle.
  - f_flush has no effect on DATA.
- f_rdata and d_rdata hold their last value between pulses.
- f_valid and d_valid are never high in the same cycle.
- busy = (state != IDLE).
- Requests that change while in FETCH or DATA are ignored until IDLE.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog clears at grant and counts every cycle in FETCH or DATA.
  - When it reaches TIMEOUT_CYCLES without bus_ack: drop bus_req and go to IDLE.
  - Next cycle: pulse err together with the matching valid, with rdata forced to 32'h0. For a dropped fetch, err pulses alone without f_valid.
- Undefined: no watchdog; err tied to 0; a stalled bus hangs the arbiter in FETCH or DATA indefinitely.

Test Plan:
- Reset check: assert irst mid-DATA with bus_ack never given -> bus_req = 0 in the same cycle, all outputs 0; after release, state is IDLE and busy = 0.
- Single fetch: f_req = 1, f_addr = 32'h100, bus_ack at bus cycle 1 with bus_rdata = 32'h00500093 -> bus_addr = 32'h100 at N+1, then f_valid = 1 with f_rdata = 32'h00500093 at N+2, no d_valid.
- Priority and starvation: f_req and d_req held continuously, zero-latency acks, DATA_BURST_MAX = 4 -> grant order D, D, D, D, F, D...; bus_wstrb = 0 on every fetch.
- Store: d_we = 1, d_addr = 32'h2000, d_wdata = 32'hDEADBEEF, d_wstrb = 4'b0011, ack after 3 cycles -> bus fields stable for all 4 request cycles; d_valid pulses once, 5 cycles after request.
- Flush: f_flush pulsed while in FETCH, ack later with bus_rdata = 32'h1234 -> f_valid stays 0 and f_rdata unchanged; next f_req with f_addr = 32'h200 is served normally.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): d_req load with no bus_ack -> bus_req drops after 8 cycles; next cycle err = 1, d_valid = 1, d_rdata = 32'h0.
